// File: rtl/disp_scan_driver_if.sv
// rtl/disp_scan_driver_if.sv - load request and scanned-digit outputs of the 4-digit display driver
interface disp_scan_driver_if;
  logic [13:0] value;
  logic        load;
  logic        busy;
  logic [31:0] digit_num;
  logic [3:0]  an;

  modport master (output value, load, input busy, digit_num, an);
  modport slave  (input value, load, output busy, digit_num, an);
endinterface

// File: rtl/disp_scan_driver.sv
// rtl/disp_scan_driver.sv - binary-to-BCD (double dabble) converter feeding a 4-digit multiplexed display
module disp_scan_driver #(
  parameter int SCAN_DIV = 50000,
  parameter bit LZ_BLANK = 1'b0
) (
  input logic               clk,
  input logic               rst,
  disp_scan_driver_if.slave bus
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CONV = 1'b1;

  logic [0:0]    state;
  logic [PW-1:0] pre;
  logic [1:0]    idx;
  logic [3:0]    step;
  logic [13:0]   bin;
  logic [15:0]   bcd;
  logic          err_pend;
  logic [15:0]   disp;
  logic          err;
  logic [15:0]   bcd_adj;
  logic [15:0]   bcd_next;
  logic [3:0]    cur;
  logic          blank;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
      idx <= idx + 2'd1;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  // One double-dabble step: add 3 to every BCD column >= 5, then shift in the next binary MSB.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    bcd_next = {bcd_adj[14:0], bin[13]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      step     <= '0;
      bin      <= '0;
      bcd      <= '0;
      err_pend <= 1'b0;
      disp     <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.load) begin
            bin      <= bus.value;
            bcd      <= '0;
            step     <= '0;
            err_pend <= (bus.value > 14'd9999);
            state    <= ST_CONV;
          end
        end
        default: begin
          bin  <= {bin[12:0], 1'b0};
          bcd  <= bcd_next;
          step <= step + 4'd1;
          // Display and error flag change together, only once the last bit is in.
          if (step == 4'd13) begin
            disp  <= bcd_next;
            err   <= err_pend;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy = (state == ST_CONV);

  always_comb begin
    cur   = disp[{idx, 2'b00} +: 4];
    blank = 1'b0;
    if (LZ_BLANK && !err) begin
      case (idx)
        2'd1:    blank = (disp[15:4] == 12'd0);
        2'd2:    blank = (disp[15:8] == 8'd0);
        2'd3:    blank = (disp[15:12] == 4'd0);
        default: blank = 1'b0;
      endcase
    end
  end

  assign bus.an        = blank ? 4'b1111 : ~(4'b0001 << idx);
  assign bus.digit_num = err ? 32'd10 : {28'd0, cur};
endmodule

// File: doc/disp_scan_driver.md
DISP_SCAN_DRIVER -- requirements
Module: disp_scan_driver

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, setting clock cycles each digit is enabled (legal range 2..2^20).
REQ-002 The block SHALL have parameter LZ_BLANK, default 0; when 1, leading-zero digits are blanked.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 value  input  14  unsigned binary number to display, sampled on accepted load.
REQ-006 load  input  1  request to convert and display value; single-cycle pulse or level.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 digit_num  output  32  current digit code for the downstream 7-segment decoder: 0..9 for a decimal digit, 10 for the error dash, zero-extended.
REQ-009 an  output  4  active-low digit enables; an[0] is the ones digit and an[3] is the thousands digit.

Function
REQ-010 A load SHALL be accepted on a clock edge where load=1, busy=0 and rst=0; value is captured on that edge.
REQ-011 A load SHALL be ignored while busy=1, with no queuing.
REQ-012 Conversion SHALL use shift-add-3 (double dabble) at one bit per cycle, MSB first.
  - busy goes high the cycle after acceptance and stays high for exactly 14 cycles.
REQ-013 On the edge ending the 14th conversion cycle, the display register (4 BCD digits) and the error flag SHALL update atomically, and busy SHALL return to 0.
REQ-014 Until a conversion completes, the display SHALL keep showing the previous result; no partially converted digits are ever visible.
REQ-015 If the captured value exceeds 9999:
  - the error flag SHALL be set at completion;
  - all four digits SHALL output digit_num=10;
  - the BCD contents are don't-care.
REQ-016 A valid (<=9999) conversion SHALL clear the error flag at completion.
REQ-017 A prescaler SHALL count 0..SCAN_DIV-1 continuously, independent of busy and load.
  - At terminal count it wraps to 0 and the digit index advances 0->1->2->3->0.
REQ-018 an SHALL equal ~(4'b0001 << index) combinationally from the registered index, with no added latency.
  - Exception: a blanked digit drives its an bit 1, so all an bits are 1 during that slot.
REQ-019 digit_num SHALL be the display-register digit selected by index, zero-extended to 32 bits; it SHALL be 10 for every index when the error flag is set.
REQ-020 With LZ_BLANK=1 and no error, digits above the most significant nonzero digit SHALL be blanked; digit 0 is never blanked, so value 0 shows "0".
REQ-021 Exactly one or zero bits of an SHALL be low in any cycle.
REQ-022 A load accepted on the same edge that a conversion completes is impossible by REQ-010, because busy is still 1 on that edge.
  - The next load is accepted one cycle later at the earliest.

Reset
REQ-023 While rst=1 on a clock edge, all of the following SHALL be cleared on that edge:
  - prescaler=0, index=0, busy=0, display register=0000, error flag=0, conversion shift state cleared;
  - giving an=4'b1110 and digit_num=0 the following cycle.
REQ-024 rst SHALL take priority over load and over an in-progress conversion.
  - A conversion interrupted by rst is discarded and never updates the display.
REQ-025 Immediately after reset, the display SHALL show 0000, or "0" on digit 0 only if LZ_BLANK=1.

Verification
REQ-026 SCAN_DIV=4, load value=1234 -> busy high 14 cycles, then over one 16-cycle scan: an=1110/1101/1011/0111 each for 4 cycles with digit_num=4/3/2/1.
REQ-027 Load 9999, then load 10000 after done -> first displays 9,9,9,9; second displays digit_num=10 on all four digits; then load 0 -> 0,0,0,0 and error cleared.
REQ-028 Load 5678, pulse load with 42 on cycle 5 of busy -> second load ignored; display 5678; busy timing unchanged.
REQ-029 Display 1234, load 8765, assert rst on busy cycle 7 -> display 0000, busy=0, an=1110 next cycle; 8765 never appears.
REQ-030 LZ_BLANK=1, load 7 -> digit 0 shows 7; slots 1..3 have an=1111; load 0 -> digit 0 shows 0.
REQ-031 Load held high continuously with value=300 -> conversions back-to-back with one idle cycle (busy=0) between them; display stable at 0300.
